// File: rtl/bdp_pkg.sv
// Shared constants and FSM encoding for the bDP bit-serial sequencer.
package bdp_pkg;

  localparam int LANES     = 8;
  localparam int ACT_W     = 8;
  localparam int BDP_RES_W = 16;
  localparam int BDP_LAT   = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/bdp_col_pick.sv
// Lowest-set-bit picker over the remaining weight column mask.
module bdp_col_pick #(
  parameter int W = 7
) (
  input  logic [W-1:0] mask,
  output logic [2:0]   idx,
  output logic [W-1:0] clr,
  output logic         empty
);

  // Isolate the lowest set bit and encode its position.
  always_comb begin
    clr   = mask & (~mask + W'(1));
    empty = (mask == {W{1'b0}});
    idx   = 3'd0;
    for (int i = 0; i < W; i++) begin
      idx = idx | (clr[i] ? 3'(i) : 3'd0);
    end
  end

endmodule

// File: rtl/bdp_seq_ctrl.sv
// Sequencer that feeds nonzero weight bit-columns to one bDP unit and
// accumulates the shifted partial sums into an 8-lane dot product.
module bdp_seq_ctrl #(
  parameter int MAG_BITS = 7,
  parameter int ACC_W    = 20,
  parameter int BDP_LAT  = bdp_pkg::BDP_LAT
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [63:0]                          in_act,
  input  logic [bdp_pkg::LANES*MAG_BITS-1:0]   in_wmag,
  input  logic [7:0]                           in_wsign,
  output logic [63:0]                          bdp_activations,
  output logic [7:0]                           bdp_weight_column,
  output logic [7:0]                           bdp_weight_sign,
  output logic [2:0]                           bdp_shift_offset,
  input  logic [15:0]                          bdp_result,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [ACC_W-1:0]                     out_data,
  output logic [3:0]                           out_cols
);

  import bdp_pkg::*;

  localparam int WM_W = LANES * MAG_BITS;

  state_t              state_r, state_s;
  logic [WM_W-1:0]     wmag_r, wmag_s;
  logic [MAG_BITS-1:0] rem_r, rem_s, col_mask_s, pick_in_s, clr_s;
  logic [2:0]          idx_s, shift_r, shift_s;
  logic                empty_s, tag_in_s, acc_clr_s;
  logic [63:0]         act_r, act_s;
  logic [7:0]          sign_r, sign_s, col_r, col_s;
  logic [3:0]          cnt_r, cnt_s;
  logic [BDP_LAT:0]    tag_r;
  logic [ACC_W-1:0]    acc_r, acc_s;
  logic                in_ready_r, out_valid_r;

  function automatic logic [7:0] col_bits(input logic [WM_W-1:0] w, input logic [2:0] k);
    logic [7:0] c;
    c = 8'd0;
    for (int i = 0; i < LANES; i++) begin
      c[i] = w[MAG_BITS*i + int'(k)];
    end
    return c;
  endfunction

  // Union of all lane magnitudes: which bit-columns carry any work.
  always_comb begin
    col_mask_s = {MAG_BITS{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      col_mask_s = col_mask_s | in_wmag[MAG_BITS*i +: MAG_BITS];
    end
  end

  // The first column is picked straight from the incoming job at accept.
  assign pick_in_s = (state_r == ST_IDLE) ? col_mask_s : rem_r;

  bdp_col_pick #(.W(MAG_BITS)) u_pick (
    .mask  (pick_in_s),
    .idx   (idx_s),
    .clr   (clr_s),
    .empty (empty_s)
  );

  // Next-state and next-issue computation.
  always_comb begin
    state_s   = state_r;
    rem_s     = rem_r;
    wmag_s    = wmag_r;
    act_s     = act_r;
    sign_s    = sign_r;
    shift_s   = shift_r;
    col_s     = 8'd0;
    tag_in_s  = 1'b0;
    cnt_s     = cnt_r;
    acc_clr_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid && in_ready_r) begin
          wmag_s    = in_wmag;
          act_s     = in_act;
          sign_s    = in_wsign;
          acc_clr_s = 1'b1;
          if (!empty_s) begin
            col_s    = col_bits(in_wmag, idx_s);
            shift_s  = idx_s;
            tag_in_s = 1'b1;
            rem_s    = col_mask_s & ~clr_s;
            cnt_s    = 4'd1;
            state_s  = ST_ISSUE;
          end else begin
            rem_s   = {MAG_BITS{1'b0}};
            cnt_s   = 4'd0;
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!empty_s) begin
          col_s    = col_bits(wmag_r, idx_s);
          shift_s  = idx_s;
          tag_in_s = 1'b1;
          rem_s    = rem_r & ~clr_s;
          cnt_s    = cnt_r + 4'd1;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Done once only the output stage may still hold a result; it is
        // accumulated on this same edge.
        if (tag_r[BDP_LAT-1:0] == {BDP_LAT{1'b0}}) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Accumulator: adds each tagged bDP result, sign-extended, with wrap.
  always_comb begin
    if (acc_clr_s) begin
      acc_s = {ACC_W{1'b0}};
    end else if (tag_r[BDP_LAT]) begin
      acc_s = acc_r + {{(ACC_W-BDP_RES_W){bdp_result[BDP_RES_W-1]}}, bdp_result};
    end else begin
      acc_s = acc_r;
    end
  end

  // State, issue registers, tag pipe and accumulator.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r     <= ST_IDLE;
      rem_r       <= {MAG_BITS{1'b0}};
      wmag_r      <= {WM_W{1'b0}};
      act_r       <= 64'd0;
      sign_r      <= 8'd0;
      shift_r     <= 3'd0;
      col_r       <= 8'd0;
      cnt_r       <= 4'd0;
      tag_r       <= {(BDP_LAT+1){1'b0}};
      acc_r       <= {ACC_W{1'b0}};
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      rem_r       <= rem_s;
      wmag_r      <= wmag_s;
      act_r       <= act_s;
      sign_r      <= sign_s;
      shift_r     <= shift_s;
      col_r       <= col_s;
      cnt_r       <= cnt_s;
      tag_r       <= {tag_r[BDP_LAT-1:0], tag_in_s};
      acc_r       <= acc_s;
      in_ready_r  <= (state_s == ST_IDLE);
      out_valid_r <= (state_s == ST_DONE);
    end
  end

  assign in_ready          = in_ready_r;
  assign out_valid         = out_valid_r;
  assign out_data          = acc_r;
  assign out_cols          = cnt_r;
  assign bdp_activations   = act_r;
  assign bdp_weight_column = col_r;
  assign bdp_weight_sign   = sign_r;
  assign bdp_shift_offset  = shift_r;

endmodule

// File: doc/bdp_seq_ctrl.md
Name: bdp_seq_ctrl

Overview:
- Bit-serial sequencer for one bDP bit-column dot-product unit.
- Accepts one job: 8 signed 8-bit activations and 8 sign-magnitude weights.
- Issues only the nonzero weight bit-columns to bDP, lowest bit first, with the matching shift offset; zero columns are skipped (bit-level sparsity).
- Accumulates the shifted partial results and returns the full 8-lane dot product over a valid/ready handshake.

Parameters:
- MAG_BITS, 7, weight magnitude width; columns 0..MAG_BITS-1; must be ≤8 (shift_offset is 3 bits).
- ACC_W, 20, accumulator/output width (signed).
- BDP_LAT, 2, issue-to-result latency of bDP in cycles.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- in_valid  in  1  job offered
- in_ready  out  1  controller can accept a job
- in_act  in  64  lane i activation at [8i+7:8i], signed
- in_wmag  in  8*MAG_BITS  lane i magnitude at [MAG_BITS*i +: MAG_BITS]
- in_wsign  in  8  lane i sign, 1 = negative
- bdp_activations  out  64  to bDP activations
- bdp_weight_column  out  8  to bDP weight_column; bit i = magnitude bit k of lane i
- bdp_weight_sign  out  8  to bDP weight_sign
- bdp_shift_offset  out  3  to bDP shift_offset = k
- bdp_result  in  16  from bDP result, signed
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  ACC_W  signed dot product
- out_cols  out  4  number of columns issued for this job (0..MAG_BITS)

Behaviour:
- Datapath contract: per-lane product = bit ? (sign ? -act : act) : 0; bDP result = (sum of products) << k, 16-bit, registered; visible BDP_LAT cycles after issue.
- Reset (rstn low at a clock edge): state IDLE, in_ready=0 during reset, out_valid=0, out_data=0, out_cols=0, bdp_weight_column=0, bdp_shift_offset=0, accumulator and tag pipe cleared.
- A job in flight is abandoned on reset; no result is produced for it.
- FSM: IDLE, ISSUE, DRAIN, DONE.
- IDLE: in_ready=1.
  - On in_valid&&in_ready at edge T: latch act, wsign, wmag.
  - Compute col_mask[k] = OR over lanes of wmag bit k. Clear acc and cnt.
  - col_mask≠0 → ISSUE; col_mask==0 → DONE with out_data=0, out_cols=0 (out_valid in cycle T+1).
- ISSUE: each cycle drive the lowest set bit k of the remaining mask:
  - weight_column = bit k of the 8 lanes; sign = latched; act = latched; shift_offset = k.
  - Clear that mask bit, cnt+1, push tag=1 into a BDP_LAT-deep tag pipe.
  - When the remaining mask becomes empty → DRAIN.
  - N set columns issue in cycles T+1..T+N, back-to-back with no bubbles.
- Outside ISSUE: bdp_weight_column=0 and tag=0 pushed; act/sign/shift hold their last values.
- Accumulate: whenever the tag-pipe output is 1, acc += sign-extend(bdp_result) to ACC_W, two's-complement wrap.
- DRAIN: wait until the tag pipe is empty and the last accumulation is done → DONE. For N>0, out_valid first asserted in cycle T+N+BDP_LAT+1.
- DONE: out_valid=1; out_data=acc and out_cols=cnt are stable while out_valid. On out_ready → IDLE. in_ready=0 while not IDLE.
- out_ready is don't-care when out_valid=0. in_valid is ignored outside IDLE. No job is lost while out_valid is held.
- Width: 16-bit bDP wrap at large shifts (e.g. -1024<<6) is a datapath property; the controller accumulates the received value unchanged.

Decomposition:
- Shared package bdp_pkg: LANES=8, ACT_W=8, BDP_RES_W=16, BDP_LAT=2, FSM state enum.
- One natural sub-module: bdp_col_pick, combinational. Input is the remaining mask; outputs are the lowest set index, a one-hot clear mask, and an empty flag.
- The tag pipe and accumulator stay inline.

Test Plan:
- act=1 all lanes, wmag=3 all, sign=0 → cols 0,1 issued at T+1,T+2; out_valid at T+5; out_data=24, out_cols=2.
- act lanes 0..7 = 1..8, wmag=0x41 lane 0 only, sign=1 → cols 0,6 only (1..5 skipped); out_data=-65, out_cols=2.
- wmag all zero, random act → out_valid at T+1; out_data=0, out_cols=0; bdp_weight_column stays 0 throughout.
- act=-128 all, wmag=0x7F all, sign alternating 0/1 → 7 consecutive issues; out_data=0, out_cols=7; random weights checked against a reference dot product.
- out_ready held low 10 cycles in DONE while in_valid=1 → out_data stable, in_ready=0; after out_ready the next job is accepted in IDLE the following cycle.
- rstn low at T+3 mid-ISSUE → next cycle out_valid=0, state IDLE; a new job (act=2, wmag=1, sign=0) yields out_data=16.
